imem_fetch_responder: RTL and testbench

//  Instruction-memory responder: the memory side of the core's fetch interface (PC out, instr in).

---
 rtl/imem_fetch_responder_pkg.sv | 27 ++
 rtl/imem_fetch_responder_if.sv | 24 ++
 rtl/imem_rsp_fifo.sv | 51 +++++
 rtl/imem_fetch_responder.sv | 111 +++++++++++
 tb/tb_imem_fetch_responder.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_fetch_responder_pkg.sv
// Shared fetch-side constants and the response bundle.
// Also used by the PC register and the control unit.
package imem_fetch_responder_pkg;

    localparam logic [63:0] RESET_PC     = 64'h0000_0000_8000_0000;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

    typedef struct packed {
        logic        err;
        logic [63:0] addr;
        logic [31:0] instr;
    } imem_rsp_t;

    localparam int RSP_W = $bits(imem_rsp_t);

    // Offset wraps mod 2^64, so addresses below the base land far out of range.
    function automatic logic fetch_err(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned words
    );
        return (addr[1:0] != 2'b00) ||
               (((addr - base) >> 2) >= 64'(words));
    endfunction

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response handshake bundle between IFU and instruction memory.
// master = core side, slave = memory responder.
interface imem_fetch_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [63:0] rsp_addr;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

endinterface

// File: rtl/imem_rsp_fifo.sv
// Synchronous FIFO holding finished fetch responses.
// Head reads as zero while empty.
module imem_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 97
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: in-order fixed-latency fetch with
// credit-based backpressure and EBREAK answers for bad addresses.
module imem_fetch_responder
    import imem_fetch_responder_pkg::*;
#(
    parameter logic [63:0] ADDR_BASE = RESET_PC,
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 2,
    parameter int          MAX_OUT   = 4,
    localparam int         IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_fetch_responder_if.slave bus,
    input  logic                 ld_en,
    input  logic [IDX_W-1:0]     ld_idx,
    input  logic [31:0]          ld_data
);

    localparam int OCC_W = $clog2(MAX_OUT + 1);
    localparam int PIPE  = LATENCY - 1;

    logic [31:0]      mem [MEM_WORDS];
    logic [OCC_W-1:0] occ;
    logic             req_fire;
    logic             rsp_fire;
    logic             req_err;
    logic [IDX_W-1:0] req_idx;
    logic             push_v;
    logic             fifo_empty;
    imem_rsp_t        req_rsp;
    imem_rsp_t        push_d;
    imem_rsp_t        head;

    assign bus.req_ready = !rst && (occ < OCC_W'(MAX_OUT));
    assign req_fire      = bus.req_valid && bus.req_ready;
    assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;
    assign req_err       = fetch_err(bus.req_addr, ADDR_BASE, MEM_WORDS);
    assign req_idx       = IDX_W'((bus.req_addr - ADDR_BASE) >> 2);

    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
    end

    // A loader write to the fetched word wins over the stored value.
    always_comb begin
        req_rsp       = '0;
        req_rsp.err   = req_err;
        req_rsp.addr  = bus.req_addr;
        req_rsp.instr = INSTR_EBREAK;
        if (!req_err) begin
            req_rsp.instr = (ld_en && ld_idx == req_idx) ?
                            ld_data : mem[req_idx];
        end
    end

    if (PIPE == 0) begin : g_direct
        assign push_v = req_fire;
        assign push_d = req_rsp;
    end else begin : g_pipe
        logic [PIPE-1:0] v_q;
        imem_rsp_t       d_q [PIPE];

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= '0;
            end else begin
                v_q[0] <= req_fire;
                for (int i = 1; i < PIPE; i++) v_q[i] <= v_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (req_fire) d_q[0] <= req_rsp;
            for (int i = 1; i < PIPE; i++) d_q[i] <= d_q[i-1];
        end

        assign push_v = v_q[PIPE-1];
        assign push_d = d_q[PIPE-1];
    end

    // Credits cover pipe plus buffer, so the FIFO can never overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else if (req_fire && !rsp_fire) begin
            occ <= occ + 1'b1;
        end else if (rsp_fire && !req_fire) begin
            occ <= occ - 1'b1;
        end
    end

    imem_rsp_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (RSP_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_v),
        .push_data (push_d),
        .pop       (rsp_fire),
        .head      (head),
        .empty     (fifo_empty)
    );

    assign bus.rsp_valid = !rst && !fifo_empty;
    assign bus.rsp_instr = head.instr;
    assign bus.rsp_addr  = head.addr;
    assign bus.rsp_err   = head.err;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Randomised and directed bench for imem_fetch_responder against a
// queue-based reference model.
module tb_imem_fetch_responder;
    import imem_fetch_responder_pkg::*;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          WORDS = 1024;
    localparam int          LAT   = 2;
    localparam int          MAXO  = 4;
    localparam logic [31:0] EBRK  = 32'h0010_0073;
    localparam logic [31:0] W5    = 32'h00A0_0513;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_en = 1'b0;
    logic [9:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;

    imem_fetch_responder_if bus();

    imem_fetch_responder dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ld_en   (ld_en),
        .ld_idx  (ld_idx),
        .ld_data (ld_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        longint      rdy;
        logic [63:0] a;
        logic [31:0] i;
        logic        er;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mm [WORDS];
    longint      e = 0;

    function automatic exp_t predict(input logic [63:0] a);
        exp_t            x;
        longint unsigned w;
        w    = (a - BASE) / 4;
        x.a  = a;
        x.rdy = 0;
        x.er = (a % 4 != 0) || (w >= longint'(WORDS));
        x.i  = EBRK;
        if (!x.er) x.i = (ld_en && ld_idx == w[9:0]) ? ld_data : mm[w[9:0]];
        return x;
    endfunction

    // Reference model: one queue holds every accepted, unanswered fetch.
    initial forever begin
        int   sz;
        bit   hv;
        exp_t x;
        @(posedge clk);
        e++;
        if (rst) begin
            q.delete();
        end else begin
            sz = q.size();
            hv = sz > 0 && q[0].rdy < e;
            if (hv && bus.rsp_ready) void'(q.pop_front());
            if (bus.req_valid && sz < MAXO) begin
                x = predict(bus.req_addr);
                x.rdy = e + LAT - 1;
                q.push_back(x);
            end
        end
        if (ld_en) mm[ld_idx] = ld_data;
    end

    initial forever begin
        bit mv;
        @(negedge clk);
        mv = !rst && q.size() > 0 && q[0].rdy <= e;
        chk("req_ready", bus.req_ready, !rst && q.size() < MAXO);
        chk("rsp_valid", bus.rsp_valid, mv);
        if (mv) begin
            chk("rsp_instr", bus.rsp_instr, q[0].i);
            chk("rsp_addr", bus.rsp_addr, q[0].a);
            chk("rsp_err", bus.rsp_err, q[0].er);
        end else if (!rst) begin
            chk("idle_instr", bus.rsp_instr, 0);
            chk("idle_addr", bus.rsp_addr, 0);
            chk("idle_err", bus.rsp_err, 0);
        end
    end

    function automatic logic [63:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r == 0)
            return BASE + 64'(4 * $urandom_range(0, 15)) + 64'($urandom_range(1, 3));
        if (r == 1)
            return BASE + 64'(4 * (WORDS + $urandom_range(0, 99)));
        if (r == 2)
            return BASE - 64'(4 * $urandom_range(1, 4));
        if (r < 6)
            return BASE + 64'(4 * $urandom_range(0, 15));
        return BASE + 64'(4 * $urandom_range(0, WORDS - 1));
    endfunction

    task automatic fetch_one(input string nm, input logic [63:0] a,
                             input logic [31:0] ei, input logic ee,
                             input logic dl, input logic [9:0] li,
                             input logic [31:0] ldd);
        int n;
        bit acc;
        bit got;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.rsp_ready = 1'b1;
        ld_en   = dl;
        ld_idx  = li;
        ld_data = ldd;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            @(negedge clk); #2;
            acc = bus.req_ready;
            n++;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        ld_en = 1'b0;
        chk({nm, "_accept"}, acc, 1);
        got = 1'b0;
        n   = 0;
        while (!got && n < 20) begin
            @(negedge clk); #2;
            n++;
            got = bus.rsp_valid;
        end
        chk({nm, "_latency"}, n, LAT);
        chk({nm, "_instr"}, bus.rsp_instr, ei);
        chk({nm, "_addr"}, bus.rsp_addr, a);
        chk({nm, "_err"}, bus.rsp_err, ee);
    endtask

    initial begin
        int cnt;
        int first;
        int last;
        int nreq;
        int acc;
        int rsp;
        int n;
        bit took;

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;

        for (int i = 0; i < WORDS; i++) begin
            @(posedge clk); #1;
            ld_en   = 1'b1;
            ld_idx  = 10'(i);
            ld_data = (i == 0) ? 32'h0000_0297 : (i == 5) ? W5 : $urandom;
        end
        @(posedge clk); #1;
        ld_en = 1'b0;
        @(negedge clk); #2;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #2;
        chk("post_rst_ready", bus.req_ready, 1);

        fetch_one("t1", BASE, 32'h0000_0297, 1'b0, 1'b0, 10'd0, 32'd0);

        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        first = -1;
        last  = -1;
        cnt   = 0;
        for (int k = 0; k < 14; k++) begin
            bus.req_valid = (k < 8);
            bus.req_addr  = BASE + 64'(4 * k);
            @(negedge clk); #2;
            if (k < 8) chk("t2_req_ready", bus.req_ready, 1);
            if (bus.rsp_valid) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
            end
            @(posedge clk); #1;
        end
        chk("t2_count", cnt, 8);
        chk("t2_consecutive", last - first, 7);

        bus.rsp_ready = 1'b0;
        nreq = 0;
        acc  = 0;
        for (int k = 0; k < 8; k++) begin
            bus.req_valid = (nreq < 6);
            bus.req_addr  = BASE + 64'(4 * (16 + nreq));
            @(negedge clk); #2;
            if (bus.req_valid && bus.req_ready) begin
                acc++;
                nreq++;
            end
            @(posedge clk); #1;
        end
        chk("t3_accepted", acc, 4);
        @(negedge clk); #2;
        chk("t3_full", bus.req_ready, 0);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        rsp = 0;
        for (int k = 0; k < 16; k++) begin
            bus.req_valid = (nreq < 6);
            bus.req_addr  = BASE + 64'(4 * (16 + nreq));
            @(negedge clk); #2;
            if (bus.req_valid && bus.req_ready) nreq++;
            if (bus.rsp_valid) rsp++;
            @(posedge clk); #1;
        end
        chk("t3_responses", rsp, 6);
        @(negedge clk); #2;
        chk("t3_ready_again", bus.req_ready, 1);

        fetch_one("t4_misalign", BASE + 64'd2, EBRK, 1'b1, 1'b0, 10'd0, 32'd0);
        fetch_one("t4_oor", BASE + 64'h1000, EBRK, 1'b1, 1'b0, 10'd0, 32'd0);
        fetch_one("t4_wrap", 64'h7FFF_FFFC, EBRK, 1'b1, 1'b0, 10'd0, 32'd0);
        fetch_one("t5_wrfirst", BASE + 64'hC, 32'h0050_0093, 1'b0,
                  1'b1, 10'd3, 32'h0050_0093);

        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = BASE + 64'(4 * (32 + k));
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #2;
            if (bus.rsp_valid) n++;
            if (k == 0) chk("t6_ready", bus.req_ready, 1);
            @(posedge clk); #1;
        end
        chk("t6_no_rsp", n, 0);
        fetch_one("t6_after", BASE + 64'd20, W5, 1'b0, 1'b0, 10'd0, 32'd0);

        @(posedge clk); #1;
        took = 1'b0;
        bus.req_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!bus.req_valid || took) begin
                bus.req_valid = ($urandom_range(0, 3) != 0);
                bus.req_addr  = rand_addr();
            end
            if (((c / 200) % 2) == 1)
                bus.rsp_ready = ($urandom_range(0, 3) == 0);
            else
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
            ld_en   = ($urandom_range(0, 7) == 0);
            ld_idx  = 10'($urandom_range(0, 15));
            ld_data = $urandom;
            @(negedge clk); #2;
            took = bus.req_valid && bus.req_ready;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        ld_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #2;
        chk("drain_empty", bus.rsp_valid, 0);

        chk("model_wrap", predict(64'h7FFF_FFFC).er, 1);
        chk("model_oor", predict(BASE + 64'h1000).er, 1);
        chk("model_last", predict(BASE + 64'hFFC).er, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
